// File: rtl/dvp_transmitter.sv
// AXI4-Stream (8-bit, tuser=SOF, tlast=EOF) to DVP parallel video output.
// Frame timing is fixed by parameters; stream stalls become underrun slots.
`timescale 1ns/1ps
module dvp_transmitter #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_WIDTH = 4,
  parameter int V_BACK      = 8,
  parameter int V_FRONT     = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic       s_tuser,
  output logic [7:0] dout,
  output logic       href,
  output logic       vsync,
  output logic       underrun,
  output logic       frame_err
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX  = max2(max2(max2(H_ACTIVE, H_BLANK), max2(VSYNC_WIDTH, V_BACK)),
                              max2(V_FRONT, 2));
  localparam int CW    = $clog2(TMAX);
  localparam int LW    = $clog2(max2(V_ACTIVE, 2));
  localparam int FRAME = H_ACTIVE * V_ACTIVE;
  localparam int BW    = $clog2(max2(FRAME, 2));

  localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VS_LAST = CW'(VSYNC_WIDTH - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(V_BACK - 1);
  localparam logic [CW-1:0] VF_LAST = CW'(V_FRONT - 1);
  localparam logic [LW-1:0] L_LAST  = LW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_LINE, S_HBLANK, S_VFRONT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] line_q, line_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [7:0]    dout_q, dout_d;
  logic          href_q, href_d;
  logic          vsync_q, vsync_d;
  logic          underrun_q, underrun_d;
  logic          frame_err_q, frame_err_d;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      beat_q      <= '0;
      dout_q      <= '0;
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      beat_q      <= beat_d;
      dout_q      <= dout_d;
      href_q      <= href_d;
      vsync_q     <= vsync_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    line_d      = line_q;
    beat_d      = beat_q;
    dout_d      = '0;
    href_d      = 1'b0;
    vsync_d     = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    s_tready    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // SOF beat is held (not consumed) until the first LINE slot.
        s_tready = ~s_tuser;
        cnt_d    = '0;
        if (s_tvalid && s_tuser) begin
          state_d = S_VSYNC;
          line_d  = '0;
          beat_d  = '0;
        end
      end
      S_VSYNC: begin
        vsync_d = 1'b1;
        if (cnt_q == VS_LAST) begin
          state_d = S_VBACK;
          cnt_d   = '0;
        end
      end
      S_VBACK: begin
        if (cnt_q == VB_LAST) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end
      end
      S_LINE: begin
        s_tready = 1'b1;
        href_d   = 1'b1;
        if (s_tvalid) begin
          dout_d      = s_tdata;
          frame_err_d = (s_tuser && (beat_q != '0)) || (s_tlast != (beat_q == B_LAST));
          if (beat_q != B_LAST) beat_d = beat_q + BW'(1);
        end else begin
          underrun_d = 1'b1;
        end
        if (cnt_q == H_LAST) begin
          cnt_d   = '0;
          state_d = (line_q < L_LAST) ? S_HBLANK : S_VFRONT;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d = S_LINE;
          cnt_d   = '0;
          line_d  = line_q + LW'(1);
        end
      end
      S_VFRONT: begin
        if (cnt_q == VF_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout      = dout_q;
  assign href      = href_q;
  assign vsync     = vsync_q;
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/dvp_transmitter.md
Name: dvp_transmitter

Overview:
Converts an 8-bit AXI4-Stream video stream back into a parallel DVP camera-style interface (dout/href/vsync) with parameterised frame timing.
- Input stream convention: tuser marks the first byte of a frame; tlast marks the last byte of a frame.
- Sits at the output of the video pipeline, driving a DVP sink or looping back into the DVP receive path for self-test.
- All logic runs in the pixel clock domain.

Parameters:
H_ACTIVE, 640, bytes per line (href-high cycles per line), >=1
V_ACTIVE, 480, lines per frame, >=1
H_BLANK, 16, href-low cycles between lines, >=1
VSYNC_WIDTH, 4, vsync-high cycles at frame start, >=1
V_BACK, 8, idle cycles from vsync falling to first href, >=1
V_FRONT, 8, idle cycles after last line before returning to IDLE, >=1

Ports:
pclk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
s_tdata  in  8  stream byte
s_tvalid  in  1  stream valid
s_tready  out  1  stream ready
s_tlast  in  1  last byte of frame
s_tuser  in  1  first byte of frame (start of frame)
dout  out  8  DVP data
href  out  1  DVP line valid
vsync  out  1  DVP frame sync, active-high
underrun  out  1  one-cycle pulse: byte slot in LINE with s_tvalid=0
frame_err  out  1  one-cycle pulse: tlast/tuser misplaced

Behaviour:
Interface and reset:
- One clock: pclk. Reset: rst, synchronous, active-high.
- dout, href, vsync, underrun and frame_err are registered.
- Reset values: all registered outputs 0; state = IDLE; all counters 0.
- s_tready is combinational from the state and s_tuser.

States:
- IDLE: vsync=0, href=0.
  - s_tready = ~s_tuser. Non-SOF beats are drained and discarded, which provides resynchronisation.
  - On s_tvalid & s_tuser: the beat is not consumed; next state VSYNC.
- VSYNC: vsync=1 for exactly VSYNC_WIDTH cycles; s_tready=0; then VBACK.
- VBACK: V_BACK cycles with vsync=0 and href=0; s_tready=0; then LINE.
- LINE: H_ACTIVE cycles; s_tready=1.
  - Each cycle: if s_tvalid, register dout<=s_tdata and href<=1.
  - If ~s_tvalid: dout<=8'h00, href<=1, underrun pulses, and the slot still counts. Line timing is never stretched.
  - After the last byte of a line:
    - if line_cnt < V_ACTIVE-1, go to HBLANK;
    - otherwise go to VFRONT.
- HBLANK: H_BLANK cycles with href=0 and s_tready=0; line_cnt increments; then LINE.
- VFRONT: V_FRONT cycles with all outputs low; then IDLE.

Latency and timing:
- A byte accepted in cycle n appears on dout with href=1 in cycle n+1.
- vsync, href and dout are aligned; registered outputs lag the state by one cycle.
- Between consecutive frames, a back-to-back SOF gives a minimum gap of V_FRONT plus one IDLE cycle.

Framing checks, on accepted beats only:
- s_tuser=1 on any beat other than the first of the frame: frame_err pulses. The data is still output (no abort).
- s_tlast=1 before the final byte (index H_ACTIVE*V_ACTIVE-1): frame_err pulses.
- s_tlast=0 on the final byte: frame_err pulses.
- Whenever the checks pulse frame_err, timing continues unchanged.
- The first beat of a frame without tuser cannot occur, because entry into VSYNC requires tuser.

Counters and boundary conditions:
- Counter widths: $clog2(max(param,2)).
- Counters reset to 0 on every state entry; no wrap-around beyond the terminal count.
- Simultaneous underrun and frame_err are impossible: frame_err requires an accepted beat, underrun requires no beat.
- rst asserted mid-frame: the next cycle shows all outputs 0, state IDLE, and s_tready follows the IDLE rule.
- s_tvalid deasserting mid-line produces underrun slots only. The stream resumes at the next slot without realignment.

Test Plan:
Bench parameters for all scenarios: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, VSYNC_WIDTH=3, V_BACK=2, V_FRONT=2.
1. Reset, then a continuous valid frame of bytes 0x10..0x17 (tuser on 0x10, tlast on 0x17) -> vsync high exactly 3 cycles; 2 idle cycles; href high 4 cycles carrying 0x10..0x13; href low 2 cycles; href high 4 cycles carrying 0x14..0x17; no underrun, no frame_err.
2. In IDLE, present 3 beats with tuser=0, then an SOF beat -> the 3 beats are accepted and dropped with vsync staying 0; the SOF beat waits with s_tready=0 until the LINE state and appears as the first dout byte.
3. Drop s_tvalid for 1 cycle at the third slot of line 0 -> dout=0x00 with href=1 in that slot and underrun pulses once; the remaining bytes shift one slot later; total href-high cycles still 8.
4. Assert tlast on byte index 5 and not on index 7 -> frame_err pulses twice (on 5 and on 7); vsync/href timing identical to scenario 1.
5. Assert rst during the second LINE state -> next cycle dout=0, href=0, vsync=0, underrun=0, frame_err=0; a new SOF after release produces a full scenario-1 frame.
6. Two frames back-to-back with SOF waiting -> second vsync rises 2 (V_FRONT) + 1 (IDLE) cycles after the last href of frame 1 plus the output register delay; both frames are checked byte-exact.
